// File: rtl/flag_servo_pkg.sv
// Shared definitions for the flag servo sequencer.
// Provides the FSM state encoding, the operation encoding, and the claw target encoding.
// The operation encoding matches the flag handler's servo_state line.
package flag_servo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM_DOWN = 3'd1,
        ST_CLAW     = 3'd2,
        ST_ARM_UP   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic OP_PICKUP   = 1'b0;
    localparam logic OP_DROPOFF  = 1'b1;

    localparam logic CLAW_OPEN   = 1'b0;
    localparam logic CLAW_CLOSED = 1'b1;

    // Arm is lowered only while reaching for or releasing the flag.
    function automatic logic arm_is_down(input state_t s);
        return (s == ST_ARM_DOWN) || (s == ST_CLAW);
    endfunction

    // A dropoff opens the claw; a pickup closes it.
    function automatic logic claw_for_op(input logic op);
        return (op == OP_DROPOFF) ? CLAW_OPEN : CLAW_CLOSED;
    endfunction

endpackage

// File: rtl/flag_servo_sequencer_timebase.sv
// Servo timebase: microsecond prescaler plus PWM frame counter.
// Latency: us_cnt and frame_end are valid combinationally from the registered counters.
// Free-running; it never stalls and starts its first frame on the first clock after reset.
module servo_timebase #(
    parameter int CLKS_PER_US = 100,
    parameter int PERIOD_US   = 20000,
    parameter int UW          = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [UW-1:0] us_cnt,
    output logic          frame_end
);

    localparam int PW = $clog2(CLKS_PER_US + 1);

    logic [PW-1:0] pre_cnt;
    logic          us_tick;

    assign us_tick   = (pre_cnt == PW'(CLKS_PER_US - 1));
    assign frame_end = us_tick && (us_cnt == UW'(PERIOD_US - 1));

    // Prescaler: divides the clock down to one tick per microsecond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (us_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Frame counter: microsecond position inside the current PWM frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt <= '0;
        end else if (us_tick) begin
            if (us_cnt == UW'(PERIOD_US - 1)) begin
                us_cnt <= '0;
            end else begin
                us_cnt <= us_cnt + UW'(1);
            end
        end
    end

endmodule

// File: rtl/flag_servo_sequencer.sv
// Flag servo sequencer: runs arm-down / claw / arm-up on a request edge and drives two servo PWMs.
// Latency: outputs registered; PWM widths change only at frame boundaries, done one cycle after the last step.
// No backpressure: edges arriving while busy are dropped, a held request never retriggers.
module flag_servo_sequencer #(
    parameter int CLKS_PER_US    = 100,
    parameter int PERIOD_US      = 20000,
    parameter int SETTLE_PERIODS = 25,
    parameter int ARM_UP_US      = 1000,
    parameter int ARM_DOWN_US    = 2000,
    parameter int CLAW_OPEN_US   = 1000,
    parameter int CLAW_CLOSED_US = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic servo_req,
    input  logic servo_state,
    output logic arm_pwm,
    output logic claw_pwm,
    output logic servo_busy,
    output logic servo_done
);

    import flag_servo_pkg::*;

    localparam int UW = $clog2(PERIOD_US + 1);
    localparam int CW = $clog2(SETTLE_PERIODS + 1);

    localparam logic [UW-1:0] ARM_UP_W      = UW'(ARM_UP_US);
    localparam logic [UW-1:0] ARM_DOWN_W    = UW'(ARM_DOWN_US);
    localparam logic [UW-1:0] CLAW_OPEN_W   = UW'(CLAW_OPEN_US);
    localparam logic [UW-1:0] CLAW_CLOSED_W = UW'(CLAW_CLOSED_US);

    logic [UW-1:0] us_cnt;
    logic          frame_end;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] frm_cnt;
    logic          op;
    logic          claw_hold;
    logic          claw_hold_nxt;
    logic          req_q;
    logic          req_rise;
    logic          step_last;
    logic [UW-1:0] arm_w;
    logic [UW-1:0] claw_w;

    servo_timebase #(
        .CLKS_PER_US (CLKS_PER_US),
        .PERIOD_US   (PERIOD_US),
        .UW          (UW)
    ) u_timebase (
        .clk       (clk),
        .rst_n     (rst_n),
        .us_cnt    (us_cnt),
        .frame_end (frame_end)
    );

    assign req_rise  = servo_req && !req_q;
    assign step_last = frame_end && (frm_cnt == CW'(SETTLE_PERIODS - 1));

    // Next-state and next claw target; the width registers need the state being entered.
    always_comb begin
        state_nxt     = state;
        claw_hold_nxt = claw_hold;
        case (state)
            ST_IDLE: begin
                if (req_rise) state_nxt = ST_ARM_DOWN;
            end
            ST_ARM_DOWN: begin
                if (step_last) begin
                    state_nxt     = ST_CLAW;
                    claw_hold_nxt = claw_for_op(op);
                end
            end
            ST_CLAW: begin
                if (step_last) state_nxt = ST_ARM_UP;
            end
            ST_ARM_UP: begin
                if (step_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer FSM with its step counter, latched op, edge detector and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            frm_cnt    <= '0;
            op         <= OP_PICKUP;
            claw_hold  <= CLAW_OPEN;
            req_q      <= 1'b0;
            servo_busy <= 1'b0;
            servo_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            claw_hold  <= claw_hold_nxt;
            req_q      <= servo_req;
            servo_busy <= (state_nxt != ST_IDLE);
            servo_done <= (state_nxt == ST_DONE);
            if (state == ST_IDLE) begin
                if (req_rise) begin
                    op      <= servo_state;
                    frm_cnt <= '0;
                end
            end else if (state != ST_DONE && frame_end) begin
                frm_cnt <= step_last ? '0 : frm_cnt + CW'(1);
            end
        end
    end

    // Width registers: reload only at a frame boundary so no pulse is ever cut or stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_w  <= ARM_UP_W;
            claw_w <= CLAW_OPEN_W;
        end else if (frame_end) begin
            arm_w  <= arm_is_down(state_nxt) ? ARM_DOWN_W : ARM_UP_W;
            claw_w <= (claw_hold_nxt == CLAW_CLOSED) ? CLAW_CLOSED_W : CLAW_OPEN_W;
        end
    end

    // PWM comparators, registered so each pulse starts the cycle after the frame wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_pwm  <= 1'b0;
            claw_pwm <= 1'b0;
        end else begin
            arm_pwm  <= (us_cnt < arm_w);
            claw_pwm <= (us_cnt < claw_w);
        end
    end

endmodule

// File: tb/tb_flag_servo_sequencer.sv
// Bench for flag_servo_sequencer: directed pickup/dropoff/reset scenarios followed by random requests.
// Every cycle the outputs are compared against a frame-arithmetic model of the servo sequence.
// Hand-computed pulse lengths and done timing pin the model to known values.
module tb_flag_servo_sequencer;

    localparam int CPU   = 2;
    localparam int PER   = 100;
    localparam int SP    = 2;
    localparam int AU    = 10;
    localparam int AD    = 20;
    localparam int CO    = 10;
    localparam int CC    = 20;
    localparam int FRAME = CPU * PER;

    logic clk = 1'b0;
    logic rst_n;
    logic servo_req;
    logic servo_state;
    logic arm_pwm;
    logic claw_pwm;
    logic servo_busy;
    logic servo_done;

    flag_servo_sequencer #(
        .CLKS_PER_US    (CPU),
        .PERIOD_US      (PER),
        .SETTLE_PERIODS (SP),
        .ARM_UP_US      (AU),
        .ARM_DOWN_US    (AD),
        .CLAW_OPEN_US   (CO),
        .CLAW_CLOSED_US (CC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .servo_req   (servo_req),
        .servo_state (servo_state),
        .arm_pwm     (arm_pwm),
        .claw_pwm    (claw_pwm),
        .servo_busy  (servo_busy),
        .servo_done  (servo_done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Model state: cycles since reset release, phase 0=idle 1=stepping 2=done cycle.
    int m_cyc = 0;
    int m_phase = 0;
    int m_fe = 0;
    int m_op = 0;
    int m_hold = 0;
    int m_req_q = 0;
    int m_arm_w = AU * CPU;
    int m_claw_w = CO * CPU;

    int arm_run = 0;
    int claw_run = 0;
    int last_arm_run = 0;
    int last_claw_run = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, cyc=%0d)", name, act, exp, $time, m_cyc);
        end
    endtask

    // Compare process: advance the model by one clock and check every output.
    initial begin
        int  pos;
        int  step;
        int  e_arm;
        int  e_claw;
        bit  rise;
        bit  fe;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_cyc    = 0;
                m_phase  = 0;
                m_fe     = 0;
                m_op     = 0;
                m_hold   = 0;
                m_req_q  = 0;
                m_arm_w  = AU * CPU;
                m_claw_w = CO * CPU;
                arm_run  = 0;
                claw_run = 0;
                check("rst_arm_pwm", arm_pwm, 0);
                check("rst_claw_pwm", claw_pwm, 0);
                check("rst_busy", servo_busy, 0);
                check("rst_done", servo_done, 0);
            end else begin
                m_cyc++;
                pos    = (m_cyc - 1) % FRAME;
                fe     = ((m_cyc % FRAME) == 0);
                e_arm  = (pos < m_arm_w) ? 1 : 0;
                e_claw = (pos < m_claw_w) ? 1 : 0;
                rise   = (servo_req == 1'b1) && (m_req_q == 0);
                m_req_q = servo_req ? 1 : 0;

                if (m_phase == 2) begin
                    m_phase = 0;
                end else if (m_phase == 0 && rise) begin
                    m_phase = 1;
                    m_fe    = 0;
                    m_op    = servo_state ? 1 : 0;
                end else if (m_phase == 1 && fe) begin
                    m_fe++;
                    if (m_fe == 3 * SP) m_phase = 2;
                end

                if (fe) begin
                    step = m_fe / SP;
                    if (m_phase == 1 && step >= 1) m_hold = (m_op == 0) ? 1 : 0;
                    m_arm_w  = (m_phase == 1 && step < 2) ? AD * CPU : AU * CPU;
                    m_claw_w = (m_hold != 0) ? CC * CPU : CO * CPU;
                end

                check("arm_pwm", arm_pwm, e_arm);
                check("claw_pwm", claw_pwm, e_claw);
                check("servo_busy", servo_busy, (m_phase != 0) ? 1 : 0);
                check("servo_done", servo_done, (m_phase == 2) ? 1 : 0);

                if (arm_pwm) arm_run++;
                else if (arm_run > 0) begin last_arm_run = arm_run; arm_run = 0; end
                if (claw_pwm) claw_run++;
                else if (claw_run > 0) begin last_claw_run = claw_run; claw_run = 0; end
                if (servo_done) begin
                    done_cnt++;
                    last_done_cyc = m_cyc;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (m_cyc < n && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        if (m_cyc < n) check("wait_bound", m_cyc, n);
    endtask

    // Stimulus: directed scenarios with literal expectations, then random traffic.
    initial begin
        rst_n       = 1'b0;
        servo_req   = 1'b0;
        servo_state = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_arm_low", arm_pwm, 0);
        check("reset_busy_low", servo_busy, 0);
        rst_n = 1'b1;

        // Idle after reset: 20-clock pulses on both lines.
        wait_cyc(450);
        check("idle_arm_run", last_arm_run, 20);
        check("idle_claw_run", last_claw_run, 20);
        check("idle_done_cnt", done_cnt, 0);

        // Pickup raised mid-frame, accepted at cycle 451.
        servo_state = 1'b0;
        servo_req   = 1'b1;
        wait_cyc(460);
        check("pick_busy", servo_busy, 1);
        wait_cyc(700);
        check("pick_arm_down_run", last_arm_run, 40);
        check("pick_claw_open_run", last_claw_run, 20);
        servo_req = 1'b0;
        wait_cyc(710);
        servo_req = 1'b1;
        wait_cyc(900);
        check("pick_claw_arm_run", last_arm_run, 40);
        check("pick_claw_closed_run", last_claw_run, 40);
        wait_cyc(1300);
        check("pick_armup_arm_run", last_arm_run, 20);
        check("pick_armup_claw_run", last_claw_run, 40);
        wait_cyc(1700);
        check("pick_done_cnt", done_cnt, 1);
        check("pick_done_cyc", last_done_cyc, 1600);
        check("pick_busy_clear", servo_busy, 0);
        wait_cyc(1900);
        check("held_claw_run", last_claw_run, 40);
        check("held_arm_run", last_arm_run, 20);
        check("held_no_retrigger", done_cnt, 1);

        // Dropoff, with servo_state toggled and servo_req dropped mid-sequence.
        servo_req = 1'b0;
        wait_cyc(2060);
        servo_state = 1'b1;
        servo_req   = 1'b1;
        wait_cyc(2100);
        servo_state = 1'b0;
        wait_cyc(2150);
        servo_req = 1'b0;
        wait_cyc(2300);
        check("drop_arm_down_run", last_arm_run, 40);
        check("drop_claw_held_run", last_claw_run, 40);
        wait_cyc(2500);
        check("drop_claw_open_run", last_claw_run, 20);
        check("drop_arm_run", last_arm_run, 40);
        wait_cyc(3300);
        check("drop_done_cnt", done_cnt, 2);
        check("drop_done_cyc", last_done_cyc, 3200);
        check("drop_idle_arm_run", last_arm_run, 20);

        // Pickup interrupted by reset during the claw step.
        wait_cyc(3450);
        servo_state = 1'b0;
        servo_req   = 1'b1;
        wait_cyc(3900);
        check("abort_busy", servo_busy, 1);
        check("abort_claw_closed_run", last_claw_run, 40);
        rst_n     = 1'b0;
        servo_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_rst_arm", arm_pwm, 0);
            check("abort_rst_claw", claw_pwm, 0);
        end
        rst_n = 1'b1;
        wait_cyc(300);
        check("abort_arm_run", last_arm_run, 20);
        check("abort_claw_run", last_claw_run, 20);
        check("abort_busy_clear", servo_busy, 0);
        check("abort_no_done", done_cnt, 2);

        // Random traffic: request toggles, operation noise, occasional resets.
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            servo_state = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) servo_req = ~servo_req;
            if ($urandom_range(0, 9999) == 0) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
